// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed program image from the UART byte stream,
// writes it word by word into instruction memory, and holds the CPU in reset
// until a complete frame has passed its checksum.
//
// Frame: MAGIC, LEN_LO, LEN_HI, 4*N data bytes (little-endian words), CSUM.
// The checksum is the XOR of the data bytes only.
module uart_boot_loader #(
  parameter int         ADDR_WIDTH     = 8,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] MAGIC          = 8'hA5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  busy,
  output logic                  load_done,
  output logic                  load_error
);

  // Timeout counter must be able to hold TIMEOUT_CYCLES-1.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  // Largest accepted word count is the full memory capacity.
  localparam logic [16:0] MAX_WORDS = 17'd1 << ADDR_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_RUN    = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // Running checksum update: XOR of every data byte.
  function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
    csum_next = csum ^ b;
  endfunction

  // A state belongs to an open frame (header, payload or checksum pending).
  function automatic logic in_frame(input logic [2:0] st);
    in_frame = (st == S_LEN_LO) || (st == S_LEN_HI) || (st == S_DATA) || (st == S_CSUM);
  endfunction

  logic [2:0]            state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  in_frame_s;
  logic                  is_magic_s;
  logic [15:0]           len_full_s;
  logic                  len_bad_s;
  logic                  last_word_s;
  logic [TW-1:0]         tmo_inc_s;
  logic                  timeout_s;

  assign in_frame_s  = in_frame(state_q);
  assign is_magic_s  = (rx_data == MAGIC);
  // Word count as it would be once the high length byte is latched.
  assign len_full_s  = {rx_data, len_q[7:0]};
  assign len_bad_s   = (len_full_s == 16'd0) || (17'(len_full_s) > MAX_WORDS);
  assign last_word_s = (17'(word_idx_q) == (17'(len_q) - 17'd1));
  assign tmo_inc_s   = tmo_q + TW'(1);
  // An arriving byte always beats the timeout in the same cycle.
  assign timeout_s   = in_frame_s && !rx_valid && (tmo_inc_s == TO_LAST);

  // Inter-byte idle counter: runs only inside a frame, cleared by every byte.
  always_comb begin
    tmo_d = {TW{1'b0}};
    if (in_frame_s && !rx_valid) begin
      tmo_d = tmo_inc_s;
    end else begin
      tmo_d = {TW{1'b0}};
    end
  end

  // Frame parser: state transitions, word assembly, checksum and write request.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (rx_valid && is_magic_s) begin
          state_d = S_LEN_LO;
        end else begin
          state_d = state_q;
        end
      end

      S_LEN_LO: begin
        if (rx_valid) begin
          len_d[7:0] = rx_data;
          state_d    = S_LEN_HI;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = state_q;
        end
      end

      S_LEN_HI: begin
        if (rx_valid) begin
          len_d      = len_full_s;
          word_idx_d = {ADDR_WIDTH{1'b0}};
          byte_idx_d = 2'd0;
          word_d     = 32'd0;
          csum_d     = 8'd0;
          if (len_bad_s) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA;
          end
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = state_q;
        end
      end

      S_DATA: begin
        if (rx_valid) begin
          csum_d = csum_next(csum_q, rx_data);
          if (byte_idx_q == 2'd3) begin
            // Fourth byte completes the word: issue the write next cycle.
            we_d       = 1'b1;
            addr_d     = word_idx_q;
            wdata_d    = {rx_data, word_q[23:0]};
            byte_idx_d = 2'd0;
            word_d     = 32'd0;
            if (last_word_s) begin
              state_d = S_CSUM;
            end else begin
              word_idx_d = word_idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
          end else begin
            word_d[{byte_idx_q, 3'b000} +: 8] = rx_data;
            byte_idx_d                        = byte_idx_q + 2'd1;
          end
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = state_q;
        end
      end

      S_CSUM: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d = S_RUN;
          end else begin
            state_d = S_ERROR;
          end
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags follow the next state so they are valid one cycle after the
  // byte that caused the transition.
  always_comb begin
    cpu_reset_d = (state_d != S_RUN);
    busy_d      = in_frame(state_d);
    done_d      = (state_d == S_RUN);
    err_d       = (state_d == S_ERROR);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= 16'd0;
      word_idx_q  <= {ADDR_WIDTH{1'b0}};
      byte_idx_q  <= 2'd0;
      word_q      <= 32'd0;
      csum_q      <= 8'd0;
      tmo_q       <= {TW{1'b0}};
      we_q        <= 1'b0;
      addr_q      <= {ADDR_WIDTH{1'b0}};
      wdata_q     <= 32'd0;
      cpu_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      tmo_q       <= tmo_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_reset_q <= cpu_reset_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign busy       = busy_q;
  assign load_done  = done_q;
  assign load_error = err_q;

endmodule
